// File: rtl/jpeg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jpeg_pkg : widths, special byte values and length clamp for the packer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package jpeg_pkg;

    localparam int CODE_LEN_W = 6;
    localparam int WORD_W     = 32;
    localparam int ACC_W      = 2 * WORD_W;

    localparam logic [7:0] MARKER_FF  = 8'hFF;
    localparam logic [7:0] STUFF_BYTE = 8'h00;

    typedef logic [7:0] jbyte_t;

    function automatic logic [CODE_LEN_W-1:0] clamp_len(input logic [CODE_LEN_W-1:0] len);
        return (len > CODE_LEN_W'(WORD_W)) ? CODE_LEN_W'(WORD_W) : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_stuffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_stuffer : 4-byte-wide push FIFO, 1 byte/cycle serializer, 0xFF->00 |
// | stuffing when BITSTREAM_STUFF_EN is defined. Rev 1.0                     |
// +--------------------------------------------------------------------------+
module byte_stuffer
    import jpeg_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_vld_i,
    input  logic [WORD_W-1:0] word_i,
`ifdef BITSTREAM_STUFF_EN
    input  logic [3:0]        nostuff_i,
`endif
    output logic              jvalid_o,
    output jbyte_t            jpeg_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
`ifdef BITSTREAM_STUFF_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;
    logic [AW:0]        free;
    logic [2:0]         n_push;
    logic               drop;
    logic               pop;
    logic [ENTRY_W-1:0] ent [4];
    logic [ENTRY_W-1:0] head;
    logic               ovf_q;
    logic               jvalid_q;
    jbyte_t             jpeg_q;
`ifdef BITSTREAM_STUFF_EN
    logic               pend_q;
`endif

    assign head = mem_q[rd_q];

    always_comb begin
`ifdef BITSTREAM_STUFF_EN
        pop = (cnt_q != '0) && !pend_q;
`else
        pop = (cnt_q != '0);
`endif
        // A pop in the same cycle frees one slot, so a full FIFO still takes a byte
        free   = DEPTH_C - cnt_q + (AW+1)'(pop);
        n_push = 3'd0;
        drop   = 1'b0;
        if (word_vld_i) begin
            if (free >= (AW+1)'(4)) begin
                n_push = 3'd4;
            end else begin
                n_push = free[2:0];
                drop   = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
`ifdef BITSTREAM_STUFF_EN
            ent[k] = {nostuff_i[3-k], word_i[WORD_W-1-8*k -: 8]};
`else
            ent[k] = word_i[WORD_W-1-8*k -: 8];
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < n_push) begin
                mem_q[wr_q + AW'(k)] <= ent[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            jvalid_q <= 1'b0;
            jpeg_q   <= '0;
`ifdef BITSTREAM_STUFF_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            wr_q  <= wr_q + AW'(n_push);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + (AW+1)'(n_push) - (AW+1)'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end
`ifdef BITSTREAM_STUFF_EN
            if (pend_q) begin
                jvalid_q <= 1'b1;
                jpeg_q   <= STUFF_BYTE;
                pend_q   <= 1'b0;
            end else if (pop) begin
                jvalid_q <= 1'b1;
                jpeg_q   <= head[7:0];
                pend_q   <= !head[8] && (head[7:0] == MARKER_FF);
            end else begin
                jvalid_q <= 1'b0;
            end
`else
            if (pop) begin
                jvalid_q <= 1'b1;
                jpeg_q   <= head;
            end else begin
                jvalid_q <= 1'b0;
            end
`endif
        end
    end

    assign jvalid_o   = jvalid_q;
    assign jpeg_o     = jpeg_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/bitstream_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bitstream_packer : MSB-first VLC packer into 32-bit words feeding the   |
// | byte stuffer; BITSTREAM_STUFF_EN enables 0xFF stuffing. Rev 1.0          |
// +--------------------------------------------------------------------------+
module bitstream_packer
    import jpeg_pkg::*;
#(
    parameter int FIFO_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_LEN_W-1:0] ilength,
    input  logic [WORD_W-1:0]     idata,
    input  logic [WORD_W-1:0]     idata_nostuff,
    output logic [2:0]            rest,
    output logic                  jvalid,
    output logic [7:0]            jpeg,
    output logic                  overflow
);

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CODE_LEN_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  word_vld_q, word_vld_d;

    logic [CODE_LEN_W-1:0] len;
    logic [ACC_W-1:0]      code_mask;
    logic [6:0]            shamt;
    logic [ACC_W-1:0]      app;
    logic [6:0]            sum;

`ifdef BITSTREAM_STUFF_EN
    logic [ACC_W-1:0]      mask_q, mask_d;
    logic [ACC_W-1:0]      app_m;
    logic [3:0]            nostuff_q, nostuff_d;
`else
    logic                  unused_nostuff;
    assign unused_nostuff = ^idata_nostuff;
`endif

    always_comb begin
        len       = clamp_len(ilength);
        code_mask = (ACC_W'(1) << len) - ACC_W'(1);
        // Existing bits sit at the top of the accumulator; the new code lands just below them
        shamt     = 7'(ACC_W) - {1'b0, fill_q} - {1'b0, len};
        app       = acc_q | (({{WORD_W{1'b0}}, idata} & code_mask) << shamt);
        sum       = {1'b0, fill_q} + {1'b0, len};

        acc_d      = app;
        fill_d     = sum[CODE_LEN_W-1:0];
        word_d     = word_q;
        word_vld_d = 1'b0;
`ifdef BITSTREAM_STUFF_EN
        app_m     = mask_q | (({{WORD_W{1'b0}}, idata_nostuff} & code_mask) << shamt);
        mask_d    = app_m;
        nostuff_d = nostuff_q;
`endif
        if (sum >= 7'(WORD_W)) begin
            word_d     = app[ACC_W-1 -: WORD_W];
            acc_d      = {app[WORD_W-1:0], {WORD_W{1'b0}}};
            fill_d     = CODE_LEN_W'(sum - 7'(WORD_W));
            word_vld_d = 1'b1;
`ifdef BITSTREAM_STUFF_EN
            mask_d     = {app_m[WORD_W-1:0], {WORD_W{1'b0}}};
            nostuff_d  = {app_m[63], app_m[55], app_m[47], app_m[39]};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            fill_q     <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
`ifdef BITSTREAM_STUFF_EN
            mask_q     <= '0;
            nostuff_q  <= '0;
`endif
        end else begin
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
`ifdef BITSTREAM_STUFF_EN
            mask_q     <= mask_d;
            nostuff_q  <= nostuff_d;
`endif
        end
    end

    assign rest = fill_q[2:0];

    byte_stuffer #(
        .DEPTH(FIFO_BYTES)
    ) u_stuffer (
        .clk        (clk),
        .rst        (rst),
        .word_vld_i (word_vld_q),
        .word_i     (word_q),
`ifdef BITSTREAM_STUFF_EN
        .nostuff_i  (nostuff_q),
`endif
        .jvalid_o   (jvalid),
        .jpeg_o     (jpeg),
        .overflow_o (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_bitstream_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bitstream_packer : directed self-checking bench for bitstream_packer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bitstream_packer;

    localparam int FB = 16;

    logic        clk;
    logic        rst;
    logic [5:0]  ilength;
    logic [31:0] idata;
    logic [31:0] idata_nostuff;
    logic [2:0]  rest;
    logic        jvalid;
    logic [7:0]  jpeg;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] outq[$];
    logic [7:0] expq[$];

    bitstream_packer #(
        .FIFO_BYTES(FB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ilength       (ilength),
        .idata         (idata),
        .idata_nostuff (idata_nostuff),
        .rest          (rest),
        .jvalid        (jvalid),
        .jpeg          (jpeg),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && jvalid) outq.push_back(jpeg);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [5:0] len, input logic [31:0] d, input logic [31:0] m);
        ilength       = len;
        idata         = d;
        idata_nostuff = m;
        @(posedge clk);
        #1;
        ilength       = '0;
        idata         = '0;
        idata_nostuff = '0;
    endtask

    // Waits (bounded) for expq.size() bytes, lets the line settle, then compares exactly
    task automatic expect_out(input string tag);
        int cyc;
        cyc = 0;
        while (outq.size() < expq.size() && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_count"}, outq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < outq.size()) chk($sformatf("%s_b%0d", tag, i), outq[i], expq[i]);
        end
        outq.delete();
        expq.delete();
    endtask

    initial begin
        rst           = 1'b0;
        ilength       = '0;
        idata         = '0;
        idata_nostuff = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_jvalid", jvalid, 0);
        chk("rst_jpeg", jpeg, 0);
        chk("rst_rest", rest, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: four 8-bit codes form one word
        send(6'd8, 32'h41, 32'h0);
        chk("t1_rest_8", rest, 0);
        send(6'd8, 32'h42, 32'h0);
        send(6'd8, 32'h43, 32'h0);
        send(6'd8, 32'h44, 32'h0);
        chk("t1_rest", rest, 0);
        expq = '{8'h41, 8'h42, 8'h43, 8'h44};
        expect_out("t1");
        chk("t1_idle_jvalid", jvalid, 0);
        chk("t1_hold_jpeg", jpeg, 8'h44);

        // Test 2: 3-bit + 5-bit codes, junk above the code length must be ignored
        send(6'd3, 32'hFFFF_FFF5, 32'h0);
        chk("t2_rest3", rest, 3);
        send(6'd5, 32'h0000_0019, 32'h0);
        chk("t2_rest0", rest, 0);
        send(6'd24, 32'h0012_3456, 32'h0);
        expq = '{8'hB9, 8'h12, 8'h34, 8'h56};
        expect_out("t2");

        // Test 3: 0xFF with stuffing enabled gets a trailing 0x00
        send(6'd8, 32'hFF, 32'h0);
        send(6'd8, 32'h12, 32'h0);
        send(6'd8, 32'h34, 32'h0);
        send(6'd8, 32'h56, 32'h0);
`ifdef BITSTREAM_STUFF_EN
        expq = '{8'hFF, 8'h00, 8'h12, 8'h34, 8'h56};
`else
        expq = '{8'hFF, 8'h12, 8'h34, 8'h56};
`endif
        expect_out("t3");

        // Test 4: marker 0xFF flagged nostuff, ilength above 32 clamps to 32
        send(6'd8, 32'hFF, 32'hFF);
        send(6'd8, 32'h12, 32'h0);
        send(6'd8, 32'h34, 32'h0);
        send(6'd8, 32'h56, 32'h0);
        expq = '{8'hFF, 8'h12, 8'h34, 8'h56};
        expect_out("t4");
        send(6'd40, 32'hA0A1_A2A3, 32'h0);
        expq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        expect_out("t4_clamp");
        chk("t4_overflow", overflow, 0);

        // Test 5: FB/4+4 full words back-to-back overrun the FIFO
        for (int j = 0; j < FB/4 + 4; j++) begin
            send(6'd32, {8'(16*j+1), 8'(16*j+2), 8'(16*j+3), 8'(16*j+4)}, 32'h0);
        end
        expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14,
                 8'h21, 8'h22, 8'h23, 8'h24, 8'h31, 8'h32, 8'h33, 8'h34,
                 8'h41, 8'h42, 8'h43, 8'h44, 8'h51, 8'h61, 8'h71};
        expect_out("t5");
        chk("t5_overflow", overflow, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_overflow_sticky", overflow, 1);

        // Test 6: async reset mid-stream with fill=13 and FIFO non-empty
        send(6'd32, 32'h0102_0304, 32'h0);
        send(6'd13, 32'h0000_1ABC, 32'h0);
        chk("t6_pre_rest", rest, 5);
        @(posedge clk);
        #1;
        chk("t6_pre_jvalid", jvalid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_jvalid", jvalid, 0);
        chk("t6_rest", rest, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_jpeg", jpeg, 0);
        repeat (2) @(posedge clk);
        #1;
        outq.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(6'd16, 32'h0000_A1B2, 32'h0);
        send(6'd16, 32'h0000_C3D4, 32'h0);
        expq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        expect_out("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
